// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data memory controller:
// request sizes, FSM states, lane masks, boundary checks and load extension.
package dmem_pkg;

   typedef enum logic [2:0] {
      SZ_WORD   = 3'b000,
      SZ_HALF_S = 3'b001,
      SZ_HALF_U = 3'b010,
      SZ_BYTE_S = 3'b011,
      SZ_BYTE_U = 3'b100
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BEAT1 = 2'b01,
      ST_BEAT2 = 2'b10
   } state_e;

   function automatic logic [3:0] size_mask(input logic [2:0] size);
      logic [3:0] mask;
      case (size)
         SZ_WORD:              mask = 4'b1111;
         SZ_HALF_S, SZ_HALF_U: mask = 4'b0011;
         SZ_BYTE_S, SZ_BYTE_U: mask = 4'b0001;
         default:              mask = 4'b0000;
      endcase
      return mask;
   endfunction

   function automatic logic size_valid(input logic [2:0] size);
      return size_mask(size) != 4'b0000;
   endfunction

   // Access spills into the next 32-bit word
   function automatic logic crosses_word(input logic [2:0] size, input logic [1:0] off);
      logic c;
      case (size)
         SZ_WORD:              c = (off != 2'b00);
         SZ_HALF_S, SZ_HALF_U: c = (off == 2'b11);
         default:              c = 1'b0;
      endcase
      return c;
   endfunction

   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
      logic m;
      case (size)
         SZ_WORD:              m = (off != 2'b00);
         SZ_HALF_S, SZ_HALF_U: m = off[0];
         default:              m = 1'b0;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [31:0] data);
      logic [31:0] r;
      case (size)
         SZ_WORD:   r = data;
         SZ_HALF_S: r = {{16{data[15]}}, data[15:0]};
         SZ_HALF_U: r = {16'h0000, data[15:0]};
         SZ_BYTE_S: r = {{24{data[7]}}, data[7:0]};
         SZ_BYTE_U: r = {24'h000000, data[7:0]};
         default:   r = 32'h0000_0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// Four independent byte lanes sharing one word index; per-lane write enable,
// combinational read. Contents are intentionally not reset.
module dmem_byte_bank #(
   parameter int WORD_IDX_W = 8
) (
   input  logic                  clk,
   input  logic [WORD_IDX_W-1:0] addr,
   input  logic [3:0]            be,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   localparam int WORDS = 2 ** WORD_IDX_W;

   for (genvar l = 0; l < 4; l++) begin : g_lane
      logic [7:0] bytes_r [WORDS];

      // Lane write on its enable
      always_ff @(posedge clk) begin
         if (be[l]) begin
            bytes_r[addr] <= wdata[8*l +: 8];
         end
      end

      assign rdata[8*l +: 8] = bytes_r[addr];
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: one request at a time over a 4-lane byte bank.
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats;
// otherwise misaligned accesses are rejected with rsp_err.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_BYTES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err
);
   localparam int BYTE_IDX_W = $clog2(DEPTH_BYTES);
   localparam int WORD_IDX_W = BYTE_IDX_W - 2;

   state_e                  state_r;
   logic                    ready_r;
   logic                    rsp_valid_r;
   logic                    err_r;
   logic [31:0]             rdata_r;
   logic                    we_r;
   logic [2:0]              size_r;
   logic [BYTE_IDX_W-1:0]   addr_r;
   logic [31:0]             wdata_r;
   logic [31:0]             lo_r;

   logic [1:0]              off_s;
   logic [WORD_IDX_W-1:0]   widx_s;
   logic [WORD_IDX_W-1:0]   bank_addr_s;
   logic [7:0]              lane_mask_s;
   logic [63:0]             wdata_sh_s;
   logic [3:0]              bank_be_s;
   logic [31:0]             bank_wdata_s;
   logic [31:0]             bank_rdata_s;
   logic                    cross_s;
   logic                    err_s;
   logic [63:0]             raw_s;
   logic [31:0]             aligned_s;
   logic [31:0]             ext_s;
   logic                    unused_addr_s;

   // Byte index is the address modulo capacity; upper address bits are don't-care
   assign unused_addr_s = ^req_addr[ADDR_WIDTH-1:BYTE_IDX_W];

   assign off_s       = addr_r[1:0];
   assign widx_s      = addr_r[BYTE_IDX_W-1:2];
   assign lane_mask_s = {4'b0000, size_mask(size_r)} << off_s;
   assign wdata_sh_s  = {32'h0000_0000, wdata_r} << {off_s, 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
   assign cross_s = crosses_word(size_r, off_s);
   assign err_s   = !size_valid(size_r);
`else
   assign cross_s = 1'b0;
   assign err_s   = !size_valid(size_r) || misaligned(size_r, off_s);
`endif

   // Beat-dependent bank address, lane enables and write data
   always_comb begin
      bank_addr_s  = widx_s;
      bank_wdata_s = wdata_sh_s[31:0];
      bank_be_s    = 4'b0000;
      case (state_r)
         ST_BEAT1: begin
            if (we_r && !err_s) begin
               bank_be_s = lane_mask_s[3:0];
            end else begin
               bank_be_s = 4'b0000;
            end
         end
         ST_BEAT2: begin
            bank_addr_s  = widx_s + WORD_IDX_W'(1'b1);
            bank_wdata_s = wdata_sh_s[63:32];
            if (we_r) begin
               bank_be_s = lane_mask_s[7:4];
            end else begin
               bank_be_s = 4'b0000;
            end
         end
         default: bank_be_s = 4'b0000;
      endcase
   end

   dmem_byte_bank #(
      .WORD_IDX_W (WORD_IDX_W)
   ) u_bank (
      .clk   (clk),
      .addr  (bank_addr_s),
      .be    (bank_be_s),
      .wdata (bank_wdata_s),
      .rdata (bank_rdata_s)
   );

   // Second beat supplies the upper word; the first beat's word was saved in lo_r
   assign raw_s     = (state_r == ST_BEAT2) ? {bank_rdata_s, lo_r} : {32'h0000_0000, bank_rdata_s};
   assign aligned_s = 32'(raw_s >> {off_s, 3'b000});
   assign ext_s     = load_extend(size_r, aligned_s);

   // Request FSM with registered handshake and response outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         err_r       <= 1'b0;
         rdata_r     <= 32'h0000_0000;
         we_r        <= 1'b0;
         size_r      <= 3'b000;
         addr_r      <= '0;
         wdata_r     <= 32'h0000_0000;
         lo_r        <= 32'h0000_0000;
      end else begin
         rsp_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid && ready_r) begin
                  we_r    <= req_we;
                  size_r  <= req_size;
                  addr_r  <= req_addr[BYTE_IDX_W-1:0];
                  wdata_r <= req_wdata;
                  ready_r <= 1'b0;
                  state_r <= ST_BEAT1;
               end
            end
            ST_BEAT1: begin
               if (!err_s && cross_s) begin
                  lo_r    <= bank_rdata_s;
                  state_r <= ST_BEAT2;
               end else begin
                  rsp_valid_r <= 1'b1;
                  err_r       <= err_s;
                  rdata_r     <= (err_s || we_r) ? 32'h0000_0000 : ext_s;
                  ready_r     <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            ST_BEAT2: begin
               rsp_valid_r <= 1'b1;
               err_r       <= 1'b0;
               rdata_r     <= we_r ? 32'h0000_0000 : ext_s;
               ready_r     <= 1'b1;
               state_r     <= ST_IDLE;
            end
            default: begin
               ready_r <= 1'b1;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rdata_r;
   assign rsp_err   = err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus random traffic
// against a byte-array reference model; follows DMEM_MISALIGN_SPLIT_EN if defined.
module tb_data_mem_ctrl;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_size = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_checks = 0;
   int n_pass = 0;

   bit [7:0]    ref_mem [DEPTH];
   logic [31:0] obs_rd, exp_rd;
   logic        obs_err, exp_err, obs_rdy;
   int          obs_lat, exp_lat;

   data_mem_ctrl #(.ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

   always #5 clk = ~clk;

   // Reference: memory as a flat byte array, access = list of consecutive bytes
   function automatic void model(input logic we, input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rd,
                                 output logic err, output int lat);
      int n, off, b;
      logic [31:0] val;
      case (size)
         3'd0:       n = 4;
         3'd1, 3'd2: n = 2;
         3'd3, 3'd4: n = 1;
         default:    n = 0;
      endcase
      off = int'(addr % 32'd4);
      err = (n == 0);
`ifndef DMEM_MISALIGN_SPLIT_EN
      if (n != 0 && (off % n) != 0) err = 1'b1;
`endif
      rd  = 32'h0;
      lat = (!err && (off + n) > 4) ? 3 : 2;
      if (err) return;
      val = 32'h0;
      for (int i = 0; i < n; i++) begin
         b = int'((addr + 32'(i)) % 32'(DEPTH));
         if (we) ref_mem[b] = wdata[8*i +: 8];
         else val[8*i +: 8] = ref_mem[b];
      end
      if (!we) begin
         case (size)
            3'd1:    rd = {{16{val[15]}}, val[15:0]};
            3'd3:    rd = {{24{val[7]}}, val[7:0]};
            default: rd = val;
         endcase
      end
   endfunction

   // Issue one request at a negedge, hold junk valid traffic while busy, collect the response
   task automatic xact(input logic we, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      bit done;
      model(we, size, addr, wdata, exp_rd, exp_err, exp_lat);
      obs_rdy   = req_ready;
      req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      obs_lat = 0;
      done = 1'b0;
      while (!done && obs_lat < 8) begin
         @(negedge clk);
         obs_lat++;
         if (rsp_valid === 1'b1) begin
            done = 1'b1;
         end else begin
            req_valid = 1'b1;
            req_we    = 1'($urandom_range(0, 1));
            req_size  = 3'($urandom_range(0, 7));
            req_addr  = $urandom();
            req_wdata = $urandom();
         end
      end
      req_valid = 1'b0;
      obs_rd  = rsp_rdata;
      obs_err = rsp_err;
      if (!done) obs_lat = 99;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", req_ready); else n_pass++;
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rsp_valid); else n_pass++;
      n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rsp_rdata); else n_pass++;
      n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_err got %b exp 0", rsp_err); else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clear();
      int bad = 0;
      for (int w = 0; w < DEPTH / 4; w++) begin
         xact(1'b1, 3'd0, 32'(w * 4), 32'h0);
         if (obs_err !== 1'b0 || obs_lat != 2 || obs_rd !== 32'h0 || obs_rdy !== 1'b1) bad++;
      end
      n_checks++; if (bad != 0) $display("FAIL clear_stores got %0d bad exp 0", bad); else n_pass++;
   endtask

   task automatic test_word();
      xact(1'b1, 3'd0, 32'h10, 32'hDEADBEEF);
      n_checks++; if (obs_lat != 2) $display("FAIL word_store_lat got %0d exp 2", obs_lat); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("FAIL word_store_err got %b exp 0", obs_err); else n_pass++;
      xact(1'b0, 3'd0, 32'h10, 32'h0);
      n_checks++; if (obs_rd !== 32'hDEADBEEF) $display("FAIL word_load got %h exp deadbeef", obs_rd); else n_pass++;
      n_checks++; if (obs_lat != 2) $display("FAIL word_load_lat got %0d exp 2", obs_lat); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("FAIL word_load_err got %b exp 0", obs_err); else n_pass++;
      n_checks++; if (obs_rdy !== 1'b1) $display("FAIL b2b_ready got %b exp 1", obs_rdy); else n_pass++;
   endtask

   task automatic test_byte();
      xact(1'b1, 3'd0, 32'h20, 32'h44332211);
      xact(1'b1, 3'd4, 32'h21, 32'h5A5A5A80);
      xact(1'b0, 3'd3, 32'h21, 32'h0);
      n_checks++; if (obs_rd !== 32'hFFFFFF80) $display("FAIL byte_sext got %h exp ffffff80", obs_rd); else n_pass++;
      xact(1'b0, 3'd4, 32'h21, 32'h0);
      n_checks++; if (obs_rd !== 32'h00000080) $display("FAIL byte_zext got %h exp 00000080", obs_rd); else n_pass++;
      xact(1'b0, 3'd1, 32'h20, 32'h0);
      n_checks++; if (obs_rd !== 32'hFFFF8011) $display("FAIL half_sext got %h exp ffff8011", obs_rd); else n_pass++;
      xact(1'b0, 3'd1, 32'h22, 32'h0);
      n_checks++; if (obs_rd !== 32'h00004433) $display("FAIL half_pos got %h exp 00004433", obs_rd); else n_pass++;
      xact(1'b0, 3'd0, 32'h20, 32'h0);
      n_checks++; if (obs_rd !== 32'h44338011) $display("FAIL byte_neighbors got %h exp 44338011", obs_rd); else n_pass++;
      repeat (2) @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) $display("FAIL pulse_width got %b exp 0", rsp_valid); else n_pass++;
      n_checks++; if (rsp_rdata !== 32'h44338011) $display("FAIL rdata_hold got %h exp 44338011", rsp_rdata); else n_pass++;
   endtask

   task automatic test_misalign();
      logic [31:0] addrs [4];
      logic [7:0]  vals [4];
`ifdef DMEM_MISALIGN_SPLIT_EN
      xact(1'b1, 3'd0, 32'h0E, 32'h11223344);
      n_checks++; if (obs_lat != 3) $display("FAIL cross_store_lat got %0d exp 3", obs_lat); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("FAIL cross_store_err got %b exp 0", obs_err); else n_pass++;
      xact(1'b0, 3'd0, 32'h0C, 32'h0);
      n_checks++; if (obs_rd !== 32'h33440000) $display("FAIL cross_lo_word got %h exp 33440000", obs_rd); else n_pass++;
      xact(1'b0, 3'd2, 32'h10, 32'h0);
      n_checks++; if (obs_rd !== 32'h00001122) $display("FAIL cross_hi_half got %h exp 00001122", obs_rd); else n_pass++;
      xact(1'b1, 3'd0, 32'h3FE, 32'hA1B2C3D4);
      n_checks++; if (obs_lat != 3) $display("FAIL wrap_store_lat got %0d exp 3", obs_lat); else n_pass++;
      addrs[0] = 32'h3FE; addrs[1] = 32'h3FF; addrs[2] = 32'h000; addrs[3] = 32'h001;
      vals[0] = 8'hD4; vals[1] = 8'hC3; vals[2] = 8'hB2; vals[3] = 8'hA1;
      for (int i = 0; i < 4; i++) begin
         xact(1'b0, 3'd4, addrs[i], 32'h0);
         n_checks++;
         if (obs_rd !== {24'h0, vals[i]}) $display("FAIL wrap_byte addr=%h got %h exp %h", addrs[i], obs_rd, {24'h0, vals[i]});
         else n_pass++;
      end
      xact(1'b0, 3'd1, 32'h3FF, 32'h0);
      n_checks++; if (obs_rd !== 32'hFFFFB2C3) $display("FAIL wrap_half got %h exp ffffb2c3", obs_rd); else n_pass++;
      n_checks++; if (obs_lat != 3) $display("FAIL wrap_half_lat got %0d exp 3", obs_lat); else n_pass++;
`else
      xact(1'b1, 3'd0, 32'h0E, 32'h11223344);
      n_checks++; if (obs_err !== 1'b1) $display("FAIL misal_store_err got %b exp 1", obs_err); else n_pass++;
      n_checks++; if (obs_lat != 2) $display("FAIL misal_store_lat got %0d exp 2", obs_lat); else n_pass++;
      xact(1'b0, 3'd0, 32'h0C, 32'h0);
      n_checks++; if (obs_rd !== 32'h0) $display("FAIL misal_no_write_lo got %h exp 0", obs_rd); else n_pass++;
      xact(1'b0, 3'd0, 32'h10, 32'h0);
      n_checks++; if (obs_rd !== 32'hDEADBEEF) $display("FAIL misal_no_write_hi got %h exp deadbeef", obs_rd); else n_pass++;
      xact(1'b0, 3'd1, 32'h05, 32'h0);
      n_checks++; if (obs_err !== 1'b1) $display("FAIL misal_half_err got %b exp 1", obs_err); else n_pass++;
      n_checks++; if (obs_rd !== 32'h0) $display("FAIL misal_half_rdata got %h exp 0", obs_rd); else n_pass++;
      xact(1'b0, 3'd2, 32'h12, 32'h0);
      n_checks++; if (obs_rd !== 32'h0000DEAD) $display("FAIL aligned_half got %h exp 0000dead", obs_rd); else n_pass++;
      n_checks++; if (obs_err !== 1'b0) $display("FAIL aligned_half_err got %b exp 0", obs_err); else n_pass++;
      addrs[0] = 32'h0; vals[0] = 8'h0;
      n_checks++; if (addrs[0] !== 32'h0 || vals[0] !== 8'h0) $display("FAIL tbl_init"); else n_pass++;
`endif
   endtask

   task automatic test_invalid_size();
      xact(1'b1, 3'd0, 32'h30, 32'h0BADF00D);
      for (int s = 5; s < 8; s++) begin
         xact(1'b1, 3'(s), 32'h30, $urandom());
         n_checks++; if (obs_err !== 1'b1) $display("FAIL inv_store_err size=%0d got %b exp 1", s, obs_err); else n_pass++;
         xact(1'b0, 3'd0, 32'h30, 32'h0);
         n_checks++; if (obs_rd !== 32'h0BADF00D) $display("FAIL inv_no_write size=%0d got %h exp 0badf00d", s, obs_rd); else n_pass++;
         xact(1'b0, 3'(s), 32'h30, 32'h0);
         n_checks++; if (obs_rd !== 32'h0 || obs_err !== 1'b1) $display("FAIL inv_load size=%0d got %h/%b exp 0/1", s, obs_rd, obs_err); else n_pass++;
         n_checks++; if (obs_lat != 2) $display("FAIL inv_load_lat size=%0d got %0d exp 2", s, obs_lat); else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      req_valid = 1'b1; req_we = 1'b1; req_size = 3'd0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      req_addr = 32'h1E; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      ref_mem[32'h1E] = 8'h0D; ref_mem[32'h1F] = 8'hF0;
`else
      req_addr = 32'h40; req_wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
`endif
      rst = 1'b1;
      #1;
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
      rst = 1'b0;
      n_checks++; if (req_ready !== 1'b1) $display("FAIL mid_reset_ready got %b exp 1", req_ready); else n_pass++;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen++;
      end
      n_checks++; if (seen != 0) $display("FAIL mid_reset_rsp got %0d pulses exp 0", seen); else n_pass++;
      for (int a = 32'h1C; a <= 32'h44; a += 4) begin
         xact(1'b0, 3'd0, 32'(a), 32'h0);
         n_checks++; if (obs_rd !== exp_rd) $display("FAIL mid_reset_mem addr=%h got %h exp %h", a, obs_rd, exp_rd); else n_pass++;
      end
   endtask

   task automatic test_random();
      logic        we;
      logic [2:0]  size;
      logic [31:0] addr, wdata;
      for (int it = 0; it < 300; it++) begin
         we    = 1'($urandom_range(0, 1));
         size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         addr  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 63)) : $urandom();
         wdata = $urandom();
         xact(we, size, addr, wdata);
         n_checks++; if (obs_rd !== exp_rd) $display("FAIL rand_rdata it=%0d we=%b size=%0d addr=%h got %h exp %h", it, we, size, addr, obs_rd, exp_rd); else n_pass++;
         n_checks++; if (obs_err !== exp_err) $display("FAIL rand_err it=%0d size=%0d addr=%h got %b exp %b", it, size, addr, obs_err, exp_err); else n_pass++;
         n_checks++; if (obs_lat != exp_lat) $display("FAIL rand_lat it=%0d size=%0d addr=%h got %0d exp %0d", it, size, addr, obs_lat, exp_lat); else n_pass++;
         n_checks++; if (obs_rdy !== 1'b1) $display("FAIL rand_ready it=%0d got %b exp 1", it, obs_rdy); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_word();
      test_byte();
      test_misalign();
      test_invalid_size();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of req_addr SHALL be as given.
REQ-002 Parameter DEPTH_BYTES, 1024, byte capacity SHALL be a power of two, >= 8.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset SHALL be asynchronous and active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  3  000 word; 001 signed half; 010 unsigned half; 011 signed byte; 100 unsigned byte.
REQ-009 req_addr  input  ADDR_WIDTH  byte address.
REQ-010 req_wdata  input  32  store data, little-endian, low bytes used for half/byte.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  load result, extended per req_size; 0 for stores and errors.
REQ-013 rsp_err  output  1  valid with rsp_valid; request rejected.

Function
REQ-014 Request SHALL be accepted on an edge where req_valid and req_ready are both 1; all request fields SHALL be captured then, and may change afterwards.
REQ-015 req_valid while req_ready=0 SHALL be ignored; the requester holds the request.
REQ-016 FSM states IDLE, BEAT1, BEAT2; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE->BEAT1 on accept; BEAT1->BEAT2 if the access crosses a 32-bit word boundary (word with addr[1:0]!=0, half with addr[1:0]=11), else BEAT1->IDLE; BEAT2->IDLE always.
REQ-018 BEAT1 SHALL access the bytes in the first word; BEAT2 the remaining bytes at the next word address.
REQ-019 rsp_valid SHALL be 1 for exactly the cycle after the final beat edge: latency 2 cycles after accept for non-crossing, 3 for crossing; a new request SHALL be accepted in that rsp_valid cycle.
REQ-020 Stores SHALL write only the addressed bytes (4/2/1); half stores for size 001 and 010, byte stores for 011 and 100.
REQ-021 Loads SHALL sign-extend for 001/011 and zero-extend for 010/100.
REQ-022 Byte index SHALL be address modulo DEPTH_BYTES; an access at the top of memory wraps to byte 0.
REQ-023 req_size 101..111 SHALL complete in BEAT1 with rsp_err=1, no memory change, rsp_rdata=0.
REQ-024 rsp_rdata and rsp_err SHALL hold their values until the next rsp_valid.

Reset
REQ-025 On rst: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; memory contents SHALL NOT be reset.
REQ-026 Reset mid-operation SHALL drop the in-flight request without a response; BEAT1 bytes already written SHALL remain.

Configuration
REQ-027 Macro DMEM_MISALIGN_SPLIT_EN defined: crossing accesses SHALL be split per REQ-017/018.
REQ-028 Macro undefined: any non-naturally-aligned access (word addr[1:0]!=0, half addr[0]=1) SHALL complete in BEAT1 with rsp_err=1, no write, rsp_rdata=0; BEAT2 SHALL be unreachable.

Structure
REQ-029 Package dmem_pkg SHALL hold the req_size encodings, the FSM state encoding and the word-crossing/alignment check function.
REQ-030 The byte array SHALL be a sub-module dmem_byte_bank (4 byte lanes, per-lane write enable, combinational read); the FSM, lane steering and extension stay in data_mem_ctrl.

Verification
REQ-031 Store word 0xDEADBEEF @0x10, load word @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each accept.
REQ-032 Store byte 0x80 @0x21, load 011 @0x21 -> 0xFFFFFF80; load 100 @0x21 -> 0x00000080; bytes 0x20,0x22,0x23 unchanged.
REQ-033 With macro: store word 0x11223344 @0x0E -> 3-cycle latency; load word @0x0C -> 0x33440000 (given zeros), load half 010 @0x10 -> 0x00001122.
REQ-034 Without macro: store word @0x0E -> rsp_err=1, memory unchanged; load half @0x05 -> rsp_err=1, rsp_rdata=0.
REQ-035 DEPTH_BYTES=1024, with macro: store word 0xA1B2C3D4 @0x3FE -> bytes 0x3FE=D4, 0x3FF=C3, 0x000=B2, 0x001=A1.
REQ-036 Assert rst during BEAT2 of a crossing store -> no rsp_valid, req_ready=1 after reset, BEAT1 bytes present; req_size=101 -> rsp_err=1.
